// File: rtl/uart_rx_periph_pkg.sv
// Shared register map, status bit positions and FSM state encoding for the UART receiver.
package uart_rx_periph_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  localparam logic [3:0] RX_DATA_OFS   = 4'h0;
  localparam logic [3:0] RX_STATUS_OFS = 4'h4;
  localparam logic [3:0] RX_CTRL_OFS   = 4'h8;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  localparam logic [31:0] RXDATA_EMPTY = 32'h8000_0000;

  function automatic logic [31:0] status_word(input logic not_empty, input logic full,
                                              input logic overrun, input logic frame_err);
    logic [31:0] w;
    w = '0;
    w[STAT_NOT_EMPTY] = not_empty;
    w[STAT_FULL]      = full;
    w[STAT_OVERRUN]   = overrun;
    w[STAT_FRAME_ERR] = frame_err;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with push, pop and flush.
// Latency: pushed byte visible at head the cycle after the push edge; pop takes effect at the edge.
// Backpressure: push into full is dropped unless a pop happens the same cycle; flush beats push.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic [7:0]                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  always_comb begin
    count   = wr_ptr_q - rd_ptr_q;
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (count == (AW+1)'(DEPTH));
    pop_ok  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    push_ok = push & (~full | pop_ok);
    head    = mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/uart_rx_periph.sv
// Memory-mapped 8N1 UART receiver: synchroniser, bit FSM, byte FIFO, registers and level interrupt.
// Latency: byte pushed at the mid-stop sample; register reads combinational; interrupt registered (1 cycle).
// Backpressure: none on the serial side; bytes arriving at a full FIFO are dropped and flag overrun.
module uart_rx_periph
  import uart_rx_periph_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        rx_valid,
  input  logic        rx,
  output logic        rx_interrupt
);
  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  logic              rx_meta_q, rx_meta_d;
  logic              rx_sync_q, rx_sync_d;
  logic              rx_prev_q, rx_prev_d;
  rx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;

  logic              byte_push;
  logic              frame_bad;
  logic              pop_req;
  logic              sts_wr;
  logic              ctrl_wr;
  logic              flush;
  logic [7:0]        fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              unused_bits;

  assign unused_bits = ^{addr[31:4], write_data[31:4], fifo_count};

  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_push = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q && rx_prev_q) begin
          state_d = ST_START;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        // Returning to IDLE at mid-stop leaves half a bit to catch the next start edge.
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          state_d   = ST_IDLE;
          byte_push = rx_sync_q;
          frame_bad = ~rx_sync_q;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop_req  = read_enable && (addr[3:0] == RX_DATA_OFS) && !fifo_empty;
    sts_wr   = write_enable && (addr[3:0] == RX_STATUS_OFS);
    ctrl_wr  = write_enable && (addr[3:0] == RX_CTRL_OFS);
    flush    = ctrl_wr && write_data[CTRL_FLUSH];
    rx_valid = read_enable | write_enable;
    // Set terms are OR-ed after the W1C mask so a same-cycle event survives the clear.
    overrun_d   = (overrun_q & ~(sts_wr & write_data[STAT_OVERRUN]))
                | (byte_push & fifo_full & ~pop_req);
    frame_err_d = (frame_err_q & ~(sts_wr & write_data[STAT_FRAME_ERR])) | frame_bad;
    irq_en_d    = ctrl_wr ? write_data[CTRL_IRQ_EN] : irq_en_q;
    irq_d       = irq_en_q & (~fifo_empty | overrun_q | frame_err_q);
    rx_interrupt = irq_q;
  end

  always_comb begin
    read_data = '0;
    case (addr[3:0])
      RX_DATA_OFS:   read_data = fifo_empty ? RXDATA_EMPTY : {24'd0, fifo_head};
      RX_STATUS_OFS: read_data = status_word(~fifo_empty, fifo_full, overrun_q, frame_err_q);
      RX_CTRL_OFS:   read_data = {31'd0, irq_en_q};
      default:       read_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (byte_push),
    .push_dat (shift_q),
    .pop      (pop_req),
    .flush    (flush),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_periph.sv
// Directed bench for uart_rx_periph: serial frames driven bit by bit, register reads checked
// against a byte-queue model of the FIFO and its flags.
module tb_uart_rx_periph;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int PUSH_C = 154;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] read_data;
  logic        rx_valid;
  logic        rx;
  logic        rx_interrupt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovr;
  logic       exp_ferr;
  logic       exp_irq_en;
  logic       irq_a;
  logic       irq_b;

  uart_rx_periph #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .rx_valid     (rx_valid),
    .rx           (rx),
    .rx_interrupt (rx_interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {28'd0, exp_ferr, exp_ovr, (exp_q.size() == DEPTH), (exp_q.size() != 0)};
  endfunction

  function automatic logic [31:0] model_pop();
    if (exp_q.size() != 0) return {24'd0, exp_q.pop_front()};
    return 32'h8000_0000;
  endfunction

  function automatic logic [31:0] exp_irq();
    return {31'd0, exp_irq_en & ((exp_q.size() != 0) | exp_ovr | exp_ferr)};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_ovr    = 1'b0;
    exp_ferr   = 1'b0;
    exp_irq_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr        = a;
    read_enable = 1'b1;
    #1;
    check(tag, read_data, exp);
    check({tag, "_ack"}, {31'd0, rx_valid}, 32'd1);
    @(negedge clk);
    read_enable = 1'b0;
  endtask

  task automatic rd_fifo(input string tag);
    logic [31:0] e;
    e = model_pop();
    rd_check(tag, 32'h0, e);
  endtask

  task automatic rd_status(input string tag);
    rd_check(tag, 32'h4, exp_status());
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr         = a;
    write_data   = d;
    write_enable = 1'b1;
    if (a == 32'h4) begin
      if (d[2]) exp_ovr = 1'b0;
      if (d[3]) exp_ferr = 1'b0;
    end else if (a == 32'h8) begin
      exp_irq_en = d[0];
      if (d[1]) exp_q.delete();
    end
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  // c counts negedges from the start-bit drive; the DUT pushes on the edge after negedge PUSH_C.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int pop_at, input int abort_at);
    logic [9:0]  bits;
    logic [31:0] e;
    bits = {stop_bit, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        rst = 1'b1;
        rx  = 1'b1;
        model_reset();
        return;
      end
      rx = bits[c / CPB];
      if (c == pop_at) begin
        addr        = 32'h0;
        read_enable = 1'b1;
        e = model_pop();
        #1;
        check("pop_with_push", read_data, e);
      end else begin
        read_enable = 1'b0;
      end
      if (c == PUSH_C) begin
        if (!stop_bit) exp_ferr = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr = 1'b1;
      end
      if (c == PUSH_C + 1) irq_a = rx_interrupt;
      if (c == PUSH_C + 2) irq_b = rx_interrupt;
    end
    rx = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    rx           = 1'b1;
    addr         = '0;
    write_data   = '0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    irq_a        = 1'b0;
    irq_b        = 1'b0;
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(4);

    // Reset state and unmapped offset
    check("rst_irq", {31'd0, rx_interrupt}, 32'd0);
    rd_status("rst_status");
    rd_fifo("rst_rxdata");
    rd_check("rst_ctrl", 32'h8, 32'd0);
    wr(32'hC, 32'hFFFF_FFFF);
    rd_check("ofs_c", 32'hC, 32'd0);
    rd_check("ofs_c_ctrl", 32'h8, 32'd0);

    // 1: single byte
    send_frame(8'hA5, 1'b1, -1, -1);
    rd_status("t1_status");
    rd_fifo("t1_data");
    rd_fifo("t1_empty");

    // 2: short glitch is a false start
    @(negedge clk);
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(3 * CPB);
    rd_status("t2_status");

    // 3: overflow by one byte
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, -1);
    rd_status("t3_status_full");
    for (int i = 0; i < 4; i++) rd_fifo("t3_data");
    rd_fifo("t3_empty");
    wr(32'h4, 32'h4);
    rd_status("t3_w1c");

    // 4: framing error and interrupt
    wr(32'h8, 32'h1);
    idle(2);
    check("t4_irq_idle", {31'd0, rx_interrupt}, exp_irq());
    send_frame(8'h3C, 1'b0, -1, -1);
    check("t4_irq_lag", {31'd0, irq_a}, 32'd0);
    check("t4_irq_set", {31'd0, irq_b}, 32'd1);
    rd_status("t4_status");
    rd_fifo("t4_empty");
    wr(32'h4, 32'h8);
    idle(2);
    check("t4_irq_clr", {31'd0, rx_interrupt}, exp_irq());
    rd_status("t4_status_clr");

    // 5: pop coincides with push into a full FIFO
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, -1, -1);
    send_frame(8'h14, 1'b1, PUSH_C, -1);
    rd_status("t5_status");
    rd_fifo("t5_data0");
    rd_fifo("t5_data1");
    idle(2);
    check("t5_irq", {31'd0, rx_interrupt}, exp_irq());
    wr(32'h8, 32'h3);
    rd_status("t5_flush");
    rd_check("t5_ctrl", 32'h8, {31'd0, exp_irq_en});

    // 6: reset mid-frame
    send_frame(8'h55, 1'b1, -1, -1);
    send_frame(8'h77, 1'b1, -1, 50);
    idle(4);
    rst = 1'b0;
    idle(2 * CPB);
    check("t6_irq", {31'd0, rx_interrupt}, 32'd0);
    rd_status("t6_status");
    rd_check("t6_ctrl", 32'h8, 32'd0);
    rd_fifo("t6_empty");
    send_frame(8'h12, 1'b1, -1, -1);
    rd_fifo("t6_data");
    rd_status("t6_status_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
